// File: rtl/uart_block_bridge.sv
// uart_block_bridge
// Host-side adapter between a UART rx/tx pair and a 128-bit block core.
// RX path: packs 16 received bytes (first byte lands in [127:120]) into blk_out
// and holds it on a valid/ready handshake, discarding stale partial frames.
// TX path: takes a 128-bit result and feeds it MSB byte first into the
// transmitter, pacing on tx_busy. The two paths share nothing but the clock.
module uart_block_bridge #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         rx_rdy,
    input  logic [7:0]   rx_data,
    output logic         rx_rdy_clr,
    input  logic         tx_busy,
    output logic         tx_wr_en,
    output logic [7:0]   tx_din,
    output logic [127:0] blk_out,
    output logic         blk_out_valid,
    input  logic         blk_out_ready,
    input  logic [127:0] res_in,
    input  logic         res_valid,
    output logic         res_ready,
    output logic         frame_drop
);

    // Counter wide enough to hold TIMEOUT_CYCLES; a zero timeout disables the check.
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        RX_COLLECT,
        RX_GUARD,
        RX_FULL
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_HOLD,
        TX_WAIT
    } tx_state_t;

    logic [1:0]    rst_sync;
    logic          rst_n;

    rx_state_t     rx_state;
    logic [3:0]    byte_cnt;
    logic [TW-1:0] to_cnt;

    tx_state_t     tx_state;
    logic [127:0]  tx_shift;
    logic [3:0]    tx_cnt;

    // Reset synchronizer: assertion is immediate, release is aligned to the clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // RX: capture bytes, assemble the block, expire stale partial frames.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_state      <= RX_COLLECT;
            blk_out       <= '0;
            blk_out_valid <= 1'b0;
            byte_cnt      <= '0;
            to_cnt        <= '0;
            rx_rdy_clr    <= 1'b0;
            frame_drop    <= 1'b0;
        end else begin
            rx_rdy_clr <= 1'b0;
            frame_drop <= 1'b0;
            case (rx_state)
                RX_COLLECT: begin
                    // A capture always beats a timeout expiring in the same cycle.
                    if (rx_rdy) begin
                        blk_out    <= {blk_out[119:0], rx_data};
                        rx_rdy_clr <= 1'b1;
                        byte_cnt   <= byte_cnt + 4'd1;
                        to_cnt     <= '0;
                        if (byte_cnt == 4'd15) begin
                            blk_out_valid <= 1'b1;
                            rx_state      <= RX_FULL;
                        end else begin
                            rx_state <= RX_GUARD;
                        end
                    end else if (TO_EN && byte_cnt != 4'd0) begin
                        if (to_cnt == TO_LAST) begin
                            byte_cnt   <= '0;
                            to_cnt     <= '0;
                            frame_drop <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                // Receiver drops rdy one cycle after the clr pulse; skip that stale cycle.
                RX_GUARD: rx_state <= RX_COLLECT;
                // Block held stable; pending bytes wait in the receiver.
                RX_FULL: begin
                    if (blk_out_ready) begin
                        blk_out_valid <= 1'b0;
                        rx_state      <= RX_COLLECT;
                    end
                end
                default: rx_state <= RX_COLLECT;
            endcase
        end
    end

    // TX: accept a result and push it out byte by byte, MSB first.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_shift  <= '0;
            tx_cnt    <= '0;
            tx_wr_en  <= 1'b0;
            tx_din    <= '0;
            res_ready <= 1'b1;
        end else begin
            tx_wr_en <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (res_valid && res_ready) begin
                        tx_shift  <= res_in;
                        tx_cnt    <= '0;
                        res_ready <= 1'b0;
                        tx_state  <= TX_LOAD;
                    end
                end
                // Only load once the transmitter is free.
                TX_LOAD: begin
                    if (!tx_busy) begin
                        tx_din   <= tx_shift[127:120];
                        tx_wr_en <= 1'b1;
                        tx_state <= TX_HOLD;
                    end
                end
                // Give the transmitter a cycle to raise busy before we look at it.
                TX_HOLD: tx_state <= TX_WAIT;
                TX_WAIT: begin
                    if (!tx_busy) begin
                        tx_shift <= {tx_shift[119:0], 8'h00};
                        tx_cnt   <= tx_cnt + 4'd1;
                        if (tx_cnt == 4'd15) begin
                            res_ready <= 1'b1;
                            tx_state  <= TX_IDLE;
                        end else begin
                            tx_state <= TX_LOAD;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_block_bridge.sv
// tb_uart_block_bridge
// Receiver/transmitter models drive the bridge; expected blocks and bytes are
// queued at stimulus time and a negedge monitor pops and compares them.
module tb_uart_block_bridge;

    logic         clock;
    logic         reset_n;
    logic         rx_rdy;
    logic [7:0]   rx_data;
    logic         rx_rdy_clr;
    logic         tx_busy;
    logic         tx_wr_en;
    logic [7:0]   tx_din;
    logic [127:0] blk_out;
    logic         blk_out_valid;
    logic         blk_out_ready;
    logic [127:0] res_in;
    logic         res_valid;
    logic         res_ready;
    logic         frame_drop;

    uart_block_bridge #(.TIMEOUT_CYCLES(50)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx_rdy        (rx_rdy),
        .rx_data       (rx_data),
        .rx_rdy_clr    (rx_rdy_clr),
        .tx_busy       (tx_busy),
        .tx_wr_en      (tx_wr_en),
        .tx_din        (tx_din),
        .blk_out       (blk_out),
        .blk_out_valid (blk_out_valid),
        .blk_out_ready (blk_out_ready),
        .res_in        (res_in),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .frame_drop    (frame_drop)
    );

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int drop_cnt = 0;
    int wr_cnt = 0;
    int last_clr_cyc = 0;
    int drop_cyc = 0;

    logic [127:0] exp_blk_q[$];
    logic [7:0]   tx_exp_q[$];
    logic [7:0]   frame_q[$];

    logic         prev_valid = 1'b0;
    logic [127:0] prev_blk = '0;
    logic         chk_drop_next = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input int detail);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: condition false (value %0d)", name, detail);
        end
    endtask

    // Transmitter model: busy for 20 cycles after each write pulse.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_wr_en) begin
                @(posedge clock);
                #1 tx_busy = 1'b1;
                repeat (20) @(posedge clock);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_valid    = 1'b0;
            chk_drop_next = 1'b0;
        end else begin
            if (rx_rdy_clr) begin
                clr_cnt++;
                last_clr_cyc = cyc;
            end
            if (frame_drop) begin
                drop_cnt++;
                drop_cyc = cyc;
            end
            if (tx_wr_en) begin
                wr_cnt++;
                chk_i("tx_busy_at_wr", int'(tx_busy), 0);
                nchk++;
                if (tx_exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL tx_unexpected_wr: got %h expected no write", tx_din);
                end else begin
                    logic [7:0] e;
                    e = tx_exp_q.pop_front();
                    if (tx_din !== e) begin
                        nfail++;
                        $display("FAIL tx_din: got %h expected %h", tx_din, e);
                    end
                end
            end
            if (chk_drop_next) begin
                chk_i("valid_drop", int'(blk_out_valid), 0);
                chk_drop_next = 1'b0;
            end else if (blk_out_valid) begin
                if (prev_valid) begin
                    chk("blk_stable", blk_out, prev_blk);
                    chk_i("no_clr_full", int'(rx_rdy_clr), 0);
                end
                if (blk_out_ready) begin
                    nchk++;
                    if (exp_blk_q.size() == 0) begin
                        nfail++;
                        $display("FAIL blk_unexpected: got %h expected no block", blk_out);
                    end else begin
                        logic [127:0] e;
                        e = exp_blk_q.pop_front();
                        if (blk_out !== e) begin
                            nfail++;
                            $display("FAIL blk_out: got %h expected %h", blk_out, e);
                        end
                    end
                    chk_drop_next = 1'b1;
                end
            end
            prev_valid = blk_out_valid;
            prev_blk   = blk_out;
        end
    end

    // Receiver model: present one byte, hold rdy until the clr pulse is seen.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        logic [127:0] blk;
        repeat (gap) @(posedge clock);
        #1 rx_data = b;
        rx_rdy = 1'b1;
        frame_q.push_back(b);
        if (frame_q.size() == 16) begin
            blk = '0;
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = frame_q[i];
            exp_blk_q.push_back(blk);
            frame_q.delete();
        end
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (rx_rdy_clr) begin
                got = 1'b1;
                break;
            end
        end
        chk_ok("rx_clr_seen", got, int'(b));
        @(posedge clock);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic send_res(input logic [127:0] v);
        bit got;
        @(posedge clock);
        #1 res_in = v;
        res_valid = 1'b1;
        for (int i = 0; i < 16; i++) tx_exp_q.push_back(v[127-8*i -: 8]);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (res_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk_ok("res_accepted", got, 0);
        @(posedge clock);
        #1 res_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input int wr0);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (tx_exp_q.size() == 0 && res_ready) begin
                done = 1'b1;
                break;
            end
        end
        chk_ok("tx_done", done, tx_exp_q.size());
        chk_i("tx_wr_count", wr_cnt - wr0, 16);
    endtask

    task automatic wait_blk_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (exp_blk_q.size() == 0 && !blk_out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk_ok("blk_done", done, exp_blk_q.size());
    endtask

    task automatic rand_frame(input int maxgap);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), int'($urandom_range(0, maxgap)));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk_i({tag, "_rx_rdy_clr"}, int'(rx_rdy_clr), 0);
        chk_i({tag, "_tx_wr_en"}, int'(tx_wr_en), 0);
        chk_i({tag, "_tx_din"}, int'(tx_din), 0);
        chk({tag, "_blk_out"}, blk_out, '0);
        chk_i({tag, "_blk_out_valid"}, int'(blk_out_valid), 0);
        chk_i({tag, "_res_ready"}, int'(res_ready), 1);
        chk_i({tag, "_frame_drop"}, int'(frame_drop), 0);
    endtask

    initial begin
        int c0, d0, w0;
        logic [7:0] b;
        reset_n       = 1'b0;
        rx_rdy        = 1'b0;
        rx_data       = '0;
        blk_out_ready = 1'b1;
        res_in        = '0;
        res_valid     = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk_reset_outputs("init");
        @(posedge clock);
        #3 reset_n = 1'b1;
        repeat (5) @(posedge clock);

        // Fixed counting pattern 00,11,..,ff.
        c0 = clr_cnt;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 17);
            send_byte(b, 0);
        end
        wait_blk_done();
        chk_i("clr_count_seq", clr_cnt - c0, 16);

        // Fixed result block.
        w0 = wr_cnt;
        send_res(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        wait_tx_done(w0);

        // Partial frame expiry.
        d0 = drop_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
        repeat (60) @(posedge clock);
        chk_i("drop_count", drop_cnt - d0, 1);
        chk_ok("drop_delay", (drop_cyc - last_clr_cyc) >= 48 && (drop_cyc - last_clr_cyc) <= 54,
               drop_cyc - last_clr_cyc);
        frame_q.delete();
        rand_frame(5);
        wait_blk_done();
        chk_i("no_extra_drop", drop_cnt - d0, 1);

        // Back-pressure with byte 17 pending.
        #1 blk_out_ready = 1'b0;
        rand_frame(3);
        fork
            send_byte(8'($urandom), 0);
            begin
                c0 = clr_cnt;
                repeat (200) @(posedge clock);
                chk_i("hold_valid", int'(blk_out_valid), 1);
                chk_i("hold_no_clr", clr_cnt - c0, 0);
                #1 blk_out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 15; i++) send_byte(8'($urandom), int'($urandom_range(0, 4)));
        wait_blk_done();

        // Concurrent RX and TX, a few rounds.
        for (int r = 0; r < 3; r++) begin
            w0 = wr_cnt;
            c0 = clr_cnt;
            fork
                send_res(rand128());
                rand_frame(8);
            join
            wait_tx_done(w0);
            wait_blk_done();
            chk_i("clr_count_conc", clr_cnt - c0, 16);
        end

        // Reset mid-frame and mid-transmission.
        w0 = wr_cnt;
        fork
            for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1);
            begin
                send_res(rand128());
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clock);
                    if (wr_cnt - w0 >= 7) break;
                end
            end
        join
        chk_i("wr_before_reset", wr_cnt - w0, 7);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        tx_exp_q.delete();
        frame_q.delete();
        exp_blk_q.delete();
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        repeat (5) @(posedge clock);
        c0 = clr_cnt;
        rand_frame(4);
        wait_blk_done();
        chk_i("clr_count_after_rst", clr_cnt - c0, 16);
        w0 = wr_cnt;
        send_res(rand128());
        wait_tx_done(w0);

        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/uart_block_bridge.md
Name: uart_block_bridge

Overview:
Full-duplex byte/block adapter on the host side of the UART receiver/transmitter pair. It consumes received bytes, packs 16 of them into a 128-bit AES block and offers the block to the cipher core over a valid/ready handshake. In the other direction it accepts a 128-bit result from the core and serializes it as 16 bytes into the UART transmitter, pacing itself on tx_busy. The RX path and TX path are independent and run concurrently.

Parameters:
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of a partial frame before the frame is discarded; 0 disables the timeout.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
rx_rdy  input  1  receiver has a byte (level; stays high until cleared).
rx_data  input  8  received byte, valid while rx_rdy=1.
rx_rdy_clr  output  1  one-cycle pulse acknowledging a received byte.
tx_busy  input  1  transmitter is shifting a byte.
tx_wr_en  output  1  one-cycle pulse loading tx_din into the transmitter.
tx_din  output  8  byte to transmit.
blk_out  output  128  assembled block; first received byte at [127:120].
blk_out_valid  output  1  blk_out holds a complete block.
blk_out_ready  input  1  core accepts blk_out.
res_in  input  128  result block from core; [127:120] is transmitted first.
res_valid  input  1  res_in is valid.
res_ready  output  1  bridge can accept res_in.
frame_drop  output  1  one-cycle pulse when a partial frame is discarded by timeout.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except res_ready=1. byte_cnt=0, shift registers=0, timeout counter=0. Both FSMs go to idle. A partial frame or an in-flight transmission is abandoned without a flush.
- RX FSM states: COLLECT, GUARD, FULL.
  - COLLECT: when rx_rdy=1, shift rx_data into blk_out as {blk_out[119:0], rx_data}. Pulse rx_rdy_clr for 1 cycle and increment byte_cnt (4 bits). Go to GUARD, or to FULL if this was byte 16 (byte_cnt 15 wraps to 0).
  - GUARD: one cycle in which rx_rdy is ignored, because the receiver clears rdy one cycle after the clr pulse. Then return to COLLECT.
  - FULL: blk_out_valid=1 from the cycle after the 16th capture. blk_out is stable and rx_rdy is neither consumed nor cleared, so receiver overrun is the receiver's concern. On blk_out_valid & blk_out_ready, deassert valid next cycle and return to COLLECT.
- Timeout: in COLLECT with byte_cnt!=0 and rx_rdy=0, the counter increments each cycle; any capture resets it to 0. When it reaches TIMEOUT_CYCLES: byte_cnt←0, counter←0, frame_drop pulses 1 cycle. blk_out contents are don't-care until valid.
- A capture and a timeout expiry in the same cycle: the capture wins and there is no drop.
- TX FSM states: IDLE, LOAD, HOLD, WAIT.
  - IDLE: res_ready=1. On res_valid & res_ready, latch res_in into the TX shift register, set tx_cnt=0, drop res_ready and go to LOAD.
  - LOAD: entered only when tx_busy=0. tx_din=shift[127:120], tx_wr_en=1 for exactly 1 cycle, then HOLD.
  - HOLD: one guard cycle so the transmitter can raise tx_busy. Then WAIT.
  - WAIT: when tx_busy=0, shift left by 8 and increment tx_cnt. If 16 bytes have been sent, go to IDLE (res_ready=1 the next cycle); otherwise go to LOAD.
- tx_din holds its last value between pulses. It is only meaningful while tx_wr_en=1.
- res_valid while res_ready=0 is ignored; the core must hold it.
- RX and TX may be active simultaneously with no interaction.

Test Plan:
- Send bytes 00,11,22,…,ff (16 bytes) with the receiver model. Required: 16 rx_rdy_clr pulses, then blk_out=00112233445566778899aabbccddeeff with blk_out_valid=1. Valid drops 1 cycle after blk_out_ready=1.
- res_in=69c4e0d86a7b0430d8cdb78070b4c55a with res_valid pulse, and the transmitter model holds busy for 20 cycles per byte. Required: exactly 16 tx_wr_en pulses carrying tx_din 69,c4,…,c5,5a in order, each only while tx_busy=0. res_ready returns to 1 after the last byte.
- TIMEOUT_CYCLES=50: send 5 bytes, then idle 60 cycles. Required: frame_drop pulses once 50 cycles after byte 5. A following 16-byte burst yields exactly the new 16 bytes in blk_out.
- Hold blk_out_ready=0 for 200 cycles after a full block while byte 17 is pending. Required: blk_out stable, no rx_rdy_clr pulse. After ready, byte 17 is captured as the first byte of the next block.
- Run the RX burst and the TX result concurrently. Required: both complete with the correct data and pulse counts.
- Assert reset_n=0 after the 7th tx_wr_en and after 9 received bytes. Required: outputs immediately 0, res_ready=1. After release, a fresh 16-byte frame assembles correctly from byte 1.
